// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register slave.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    DEV,
    DEV_ACK,
    PTR,
    PTR_ACK,
    WDAT,
    WDAT_ACK,
    RDAT,
    RDAT_ACK,
    WAIT_STOP
  } i2c_state_t;

  localparam int               CNT_W   = 4;
  // Data bits are counted 1..8; a count of 8 at an SCL fall means the ACK slot starts.
  localparam logic [CNT_W-1:0] ACK_BIT = 4'd8;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronises raw SCL/SDA, optionally majority-filters them, and flags SCL edges and START/STOP.
// Latency: 3 system1000 cycles from pin to edge/condition pulse (+2 with I2C_SLAVE_REGS_GLITCH_FILTER_EN).
// Backpressure: none; free-running, one pulse per bus event.
// Ports: system1000/system1000_rstn clock and async active-low reset; i_scl/i_sda raw bus lines;
//        o_sda conditioned SDA level; o_scl_rise/o_scl_fall/o_start/o_stop one-cycle event pulses.
// Config: I2C_SLAVE_REGS_GLITCH_FILTER_EN adds a 3-sample majority filter after the synchronisers.
module i2c_line_sync
  import i2c_pkg::*;
(
  input  logic system1000,
  input  logic system1000_rstn,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  logic [1:0] r_scl_sync;
  logic [1:0] r_sda_sync;
  logic       r_scl_d;
  logic       r_sda_d;
  logic       w_scl;
  logic       w_sda;

  // Reset to 1 so an idle (pulled-up) bus produces no spurious edges on reset release.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
    end else begin
      r_scl_sync <= {r_scl_sync[0], i_scl};
      r_sda_sync <= {r_sda_sync[0], i_sda};
    end
  end

`ifdef I2C_SLAVE_REGS_GLITCH_FILTER_EN
  logic [2:0] r_scl_win;
  logic [2:0] r_sda_win;
  logic       r_scl_flt;
  logic       r_sda_flt;

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      r_scl_win <= 3'b111;
      r_sda_win <= 3'b111;
      r_scl_flt <= 1'b1;
      r_sda_flt <= 1'b1;
    end else begin
      r_scl_win <= {r_scl_win[1:0], r_scl_sync[1]};
      r_sda_win <= {r_sda_win[1:0], r_sda_sync[1]};
      r_scl_flt <= maj3(r_scl_win);
      r_sda_flt <= maj3(r_sda_win);
    end
  end

  assign w_scl = r_scl_flt;
  assign w_sda = r_sda_flt;
`else
  assign w_scl = r_scl_sync[1];
  assign w_sda = r_sda_sync[1];
`endif

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      r_scl_d <= 1'b1;
      r_sda_d <= 1'b1;
    end else begin
      r_scl_d <= w_scl;
      r_sda_d <= w_sda;
    end
  end

  assign o_sda      = w_sda;
  assign o_scl_rise = w_scl & ~r_scl_d;
  assign o_scl_fall = ~w_scl & r_scl_d;
  // SCL must be high both now and in the previous sample so an SCL edge is never read as START/STOP.
  assign o_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign o_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C slave exposing NREG 8-bit registers through an auto-incrementing pointer.
// Latency: bus events act ~3 system1000 cycles after the pin edge; wr_en fires at the SCL fall opening the ACK slot.
// Backpressure: none; the slave never stretches SCL, rd_data must be valid combinationally from rd_addr.
// Ports: system1000/system1000_rstn clock and async active-low reset; scl_in/sda_in raw bus; sda_oe open-drain pull-down;
//        wr_en/wr_addr/wr_data register write strobe; rd_addr/rd_data register read; start_det/stop_det/busy status.
// Config: I2C_SLAVE_REGS_GLITCH_FILTER_EN (see i2c_line_sync) adds a majority filter on SCL/SDA.
module i2c_slave_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h42,
  parameter int         NREG     = 16,
  parameter int         PTR_W    = $clog2(NREG)
) (
  input  logic             system1000,
  input  logic             system1000_rstn,
  input  logic             scl_in,
  input  logic             sda_in,
  output logic             sda_oe,
  output logic             wr_en,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  output logic [PTR_W-1:0] rd_addr,
  input  logic [7:0]       rd_data,
  output logic             start_det,
  output logic             stop_det,
  output logic             busy
);

  logic w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

  i2c_line_sync u_line_sync (
    .system1000      (system1000),
    .system1000_rstn (system1000_rstn),
    .i_scl           (scl_in),
    .i_sda           (sda_in),
    .o_sda           (w_sda),
    .o_scl_rise      (w_scl_rise),
    .o_scl_fall      (w_scl_fall),
    .o_start         (w_start),
    .o_stop          (w_stop)
  );

  i2c_state_t       r_state,   w_state_nxt;
  logic [CNT_W-1:0] r_bitcnt,  w_bitcnt_nxt;
  logic [7:0]       r_shift,   w_shift_nxt;
  logic [PTR_W-1:0] r_ptr,     w_ptr_nxt, w_ptr_inc;
  logic             r_rw,      w_rw_nxt;
  logic             r_mack,    w_mack_nxt;
  logic             r_sda_oe,  w_sda_oe_nxt;
  logic             r_busy,    w_busy_nxt;
  logic             r_wr_en,   w_wr_en_nxt;
  logic [PTR_W-1:0] r_wr_addr, w_wr_addr_nxt;
  logic [7:0]       r_wr_data, w_wr_data_nxt;
  logic             r_start_det, r_stop_det;

  assign w_ptr_inc = (r_ptr == PTR_W'(NREG - 1)) ? '0 : r_ptr + PTR_W'(1);

  always_comb begin
    w_state_nxt   = r_state;
    w_bitcnt_nxt  = r_bitcnt;
    w_shift_nxt   = r_shift;
    w_ptr_nxt     = r_ptr;
    w_rw_nxt      = r_rw;
    w_mack_nxt    = r_mack;
    w_sda_oe_nxt  = r_sda_oe;
    w_busy_nxt    = r_busy;
    w_wr_en_nxt   = 1'b0;
    w_wr_addr_nxt = r_wr_addr;
    w_wr_data_nxt = r_wr_data;

    // Bus conditions pre-empt any bit work; a partial byte is simply dropped.
    if (w_stop) begin
      w_state_nxt  = IDLE;
      w_sda_oe_nxt = 1'b0;
      w_bitcnt_nxt = '0;
      w_busy_nxt   = 1'b0;
    end else if (w_start) begin
      w_state_nxt  = DEV;
      w_sda_oe_nxt = 1'b0;
      w_bitcnt_nxt = '0;
    end else if (w_scl_rise) begin
      case (r_state)
        DEV, PTR, WDAT: begin
          w_shift_nxt  = {r_shift[6:0], w_sda};
          w_bitcnt_nxt = r_bitcnt + CNT_W'(1);
        end
        RDAT, DEV_ACK, PTR_ACK, WDAT_ACK: w_bitcnt_nxt = r_bitcnt + CNT_W'(1);
        RDAT_ACK: begin
          w_bitcnt_nxt = r_bitcnt + CNT_W'(1);
          w_mack_nxt   = ~w_sda;
        end
        default: ;
      endcase
    end else if (w_scl_fall) begin
      case (r_state)
        DEV: if (r_bitcnt == ACK_BIT) begin
          if (r_shift[7:1] == DEV_ADDR) begin
            w_state_nxt  = DEV_ACK;
            w_sda_oe_nxt = 1'b1;
            w_rw_nxt     = r_shift[0];
            w_busy_nxt   = 1'b1;
          end else begin
            w_state_nxt  = WAIT_STOP;
          end
        end
        DEV_ACK: begin
          w_bitcnt_nxt = '0;
          if (r_rw) begin
            w_state_nxt  = RDAT;
            w_shift_nxt  = rd_data;
            w_sda_oe_nxt = ~rd_data[7];
          end else begin
            w_state_nxt  = PTR;
            w_sda_oe_nxt = 1'b0;
          end
        end
        PTR: if (r_bitcnt == ACK_BIT) begin
          if ({24'd0, r_shift} < 32'(NREG)) begin
            w_ptr_nxt    = r_shift[PTR_W-1:0];
            w_state_nxt  = PTR_ACK;
            w_sda_oe_nxt = 1'b1;
          end else begin
            w_state_nxt  = WAIT_STOP;
          end
        end
        WDAT: if (r_bitcnt == ACK_BIT) begin
          w_wr_en_nxt   = 1'b1;
          w_wr_addr_nxt = r_ptr;
          w_wr_data_nxt = r_shift;
          w_ptr_nxt     = w_ptr_inc;
          w_state_nxt   = WDAT_ACK;
          w_sda_oe_nxt  = 1'b1;
        end
        PTR_ACK, WDAT_ACK: begin
          w_state_nxt  = WDAT;
          w_sda_oe_nxt = 1'b0;
          w_bitcnt_nxt = '0;
        end
        RDAT: begin
          if (r_bitcnt == ACK_BIT) begin
            w_state_nxt  = RDAT_ACK;
            w_sda_oe_nxt = 1'b0;
            w_ptr_nxt    = w_ptr_inc;
          end else begin
            w_shift_nxt  = {r_shift[6:0], 1'b0};
            w_sda_oe_nxt = ~r_shift[6];
          end
        end
        RDAT_ACK: begin
          w_bitcnt_nxt = '0;
          // rd_addr already shows the incremented pointer, so rd_data is the next byte.
          if (r_mack) begin
            w_state_nxt  = RDAT;
            w_shift_nxt  = rd_data;
            w_sda_oe_nxt = ~rd_data[7];
          end else begin
            w_state_nxt  = WAIT_STOP;
            w_sda_oe_nxt = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      r_state     <= IDLE;
      r_bitcnt    <= '0;
      r_shift     <= '0;
      r_ptr       <= '0;
      r_rw        <= 1'b0;
      r_mack      <= 1'b0;
      r_sda_oe    <= 1'b0;
      r_busy      <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_start_det <= 1'b0;
      r_stop_det  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bitcnt    <= w_bitcnt_nxt;
      r_shift     <= w_shift_nxt;
      r_ptr       <= w_ptr_nxt;
      r_rw        <= w_rw_nxt;
      r_mack      <= w_mack_nxt;
      r_sda_oe    <= w_sda_oe_nxt;
      r_busy      <= w_busy_nxt;
      r_wr_en     <= w_wr_en_nxt;
      r_wr_addr   <= w_wr_addr_nxt;
      r_wr_data   <= w_wr_data_nxt;
      r_start_det <= w_start;
      r_stop_det  <= w_stop;
    end
  end

  assign sda_oe    = r_sda_oe;
  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign rd_addr   = r_ptr;
  assign start_det = r_start_det;
  assign stop_det  = r_stop_det;
  assign busy      = r_busy;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bench for i2c_slave_regs: bit-banged I2C master, register model, scoreboard monitors.
// Latency: n/a.
// Backpressure: n/a.
module tb_i2c_slave_regs;

  localparam int NREG  = 16;
  localparam int PTR_W = 4;
  localparam int Q     = 200;  // quarter SCL period (20 system clocks)

  logic clk   = 1'b0;
  logic rstn  = 1'b0;
  logic scl   = 1'b1;
  logic m_sda = 1'b1;
  logic sda_bus;
  logic sda_oe, wr_en, start_det, stop_det, busy;
  logic [PTR_W-1:0] wr_addr, rd_addr;
  logic [7:0] wr_data, rd_data;
  logic [7:0] mem [NREG];

  assign sda_bus = m_sda & ~sda_oe;
  assign rd_data = mem[rd_addr];

  always #5 clk = ~clk;

  i2c_slave_regs dut (
    .system1000      (clk),
    .system1000_rstn (rstn),
    .scl_in          (scl),
    .sda_in          (sda_bus),
    .sda_oe          (sda_oe),
    .wr_en           (wr_en),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .rd_addr         (rd_addr),
    .rd_data         (rd_data),
    .start_det       (start_det),
    .stop_det        (stop_det),
    .busy            (busy)
  );

  int checks = 0, failures = 0;
  int n_start = 0, n_stop = 0, n_oe = 0;
  int e_start = 0, e_stop = 0;
  logic [15:0] q_wr[$];
  logic [7:0]  q_exp_v[$];
  string       q_exp_nm[$];
  logic [7:0]  q_obs[$];
  logic [7:0]  obs;
  logic [15:0] wexp;
  logic        b;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Monitor: compares DUT activity against the expected queues as it appears.
  always @(negedge clk) begin
    if (start_det) n_start++;
    if (stop_det) n_stop++;
    if (sda_oe) n_oe++;
    if (wr_en) begin
      if (q_wr.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_wr: got addr %0h data %0h expected no write", wr_addr, wr_data);
      end else begin
        wexp = q_wr.pop_front();
        chk("wr_en_addr_data", {8'(wr_addr), wr_data}, wexp);
      end
    end
    if (q_obs.size() != 0) begin
      obs = q_obs.pop_front();
      if (q_exp_v.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_bus_obs: got %0h expected nothing", obs);
      end else begin
        chk(q_exp_nm.pop_front(), obs, q_exp_v.pop_front());
      end
    end
  end

  task automatic bus_start();
    m_sda = 1'b1; #Q; scl = 1'b1; #Q; m_sda = 1'b0; #Q; scl = 1'b0; #Q;
    e_start++;
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; #Q; scl = 1'b1; #Q; m_sda = 1'b1; #(4*Q);
    e_stop++;
  endtask

  task automatic send_bit(input logic v);
    m_sda = v; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
  endtask

  task automatic read_bit(output logic v);
    m_sda = 1'b1; #Q; scl = 1'b1; #Q; v = sda_bus; #Q; scl = 1'b0; #Q;
  endtask

  task automatic wbyte(input string nm, input logic [7:0] d, input logic exp_ack);
    logic a;
    q_exp_nm.push_back(nm); q_exp_v.push_back({7'd0, exp_ack});
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    read_bit(a);
    q_obs.push_back({7'd0, ~a});
  endtask

  task automatic rbyte(input string nm, input logic [7:0] exp, input logic mack);
    logic [7:0] d;
    logic       v;
    q_exp_nm.push_back(nm); q_exp_v.push_back(exp);
    for (int i = 7; i >= 0; i--) begin read_bit(v); d[i] = v; end
    q_obs.push_back(d);
    send_bit(~mack);
  endtask

  task automatic chk_events(input string nm);
    chk({nm, "_start_pulses"}, n_start, e_start);
    chk({nm, "_stop_pulses"}, n_stop, e_stop);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NREG; i++) mem[i] = 8'(i);
    mem[2] = 8'hC3; mem[3] = 8'h96; mem[5] = 8'h0F;

    #20;
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_start_det", start_det, 0);
    chk("rst_stop_det", stop_det, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_addr", rd_addr, 0);
    #50 rstn = 1'b1;
    #200;

    // Write two data bytes starting at register 3.
    q_wr.push_back({8'd3, 8'hA5}); q_wr.push_back({8'd4, 8'h5A});
    bus_start();
    wbyte("t1_ack_dev", 8'h84, 1'b1);
    wbyte("t1_ack_ptr", 8'h03, 1'b1);
    chk("t1_busy_on", busy, 1);
    wbyte("t1_ack_d0", 8'hA5, 1'b1);
    wbyte("t1_ack_d1", 8'h5A, 1'b1);
    bus_stop();
    chk("t1_busy_off", busy, 0);
    chk_events("t1");

    // Set pointer to 2, repeated START, read two bytes.
    bus_start();
    wbyte("t2_ack_dev", 8'h84, 1'b1);
    wbyte("t2_ack_ptr", 8'h02, 1'b1);
    bus_start();
    wbyte("t2_ack_devr", 8'h85, 1'b1);
    rbyte("t2_rd_reg2", 8'hC3, 1'b1);
    rbyte("t2_rd_reg3", 8'h96, 1'b0);
    bus_stop();
    chk("t2_ptr_end", rd_addr, 4);
    chk_events("t2");

    // Wrong device address: NACK, bus never driven.
    n_oe = 0;
    bus_start();
    wbyte("t3_nack_dev", 8'h86, 1'b0);
    wbyte("t3_nack_data", 8'h11, 1'b0);
    chk("t3_busy", busy, 0);
    bus_stop();
    chk("t3_sda_oe_cycles", n_oe, 0);

    // Out-of-range pointer is NACKed and leaves the pointer alone.
    bus_start();
    wbyte("t4_ack_dev", 8'h84, 1'b1);
    wbyte("t4_nack_ptr16", 8'h10, 1'b0);
    bus_stop();
    chk("t4_ptr_kept", rd_addr, 4);
    // Writes wrap from the last register to 0.
    q_wr.push_back({8'd15, 8'h11}); q_wr.push_back({8'd0, 8'h22});
    bus_start();
    wbyte("t4_ack_dev2", 8'h84, 1'b1);
    wbyte("t4_ack_ptr15", 8'h0F, 1'b1);
    wbyte("t4_ack_w15", 8'h11, 1'b1);
    wbyte("t4_ack_w0", 8'h22, 1'b1);
    bus_stop();
    chk("t4_ptr_wrap", rd_addr, 1);
    chk_events("t4");

    // STOP after four data bits: no write.
    bus_start();
    wbyte("t5_ack_dev", 8'h84, 1'b1);
    wbyte("t5_ack_ptr", 8'h01, 1'b1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    bus_stop();
    chk("t5_busy_off", busy, 0);
    chk("t5_ptr", rd_addr, 1);
    chk_events("t5");

    // Reset in the middle of a read releases SDA at once.
    bus_start();
    wbyte("t6_ack_dev", 8'h84, 1'b1);
    wbyte("t6_ack_ptr", 8'h05, 1'b1);
    bus_start();
    wbyte("t6_ack_devr", 8'h85, 1'b1);
    read_bit(b); chk("t6_bit7", b, 0);
    read_bit(b); chk("t6_bit6", b, 0);
    chk("t6_oe_before_rst", sda_oe, 1);
    rstn = 1'b0;
    #1;
    chk("t6_oe_in_rst", sda_oe, 0);
    #100 rstn = 1'b1;
    n_oe = 0;
    for (int i = 0; i < 9; i++) send_bit(1'b0);
    m_sda = 1'b1; #Q; scl = 1'b1; #(4*Q);
    chk("t6_oe_after_rst", n_oe, 0);
    chk("t6_busy", busy, 0);
    chk_events("t6");

    #(4*Q);
    chk("wr_queue_drained", q_wr.size(), 0);
    chk("bus_queue_drained", q_exp_v.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_slave_regs.md
I2C_SLAVE_REGS -- requirements
Module: i2c_slave_regs

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h42: 7-bit slave address matched after START.
REQ-002 SHALL have parameter NREG, default 16, range 2..256: number of addressable 8-bit registers.
REQ-003 SHALL have parameter PTR_W, default $clog2(NREG): width of the register pointer.
REQ-004 SHALL have port system1000  in  1: system clock; all state is clocked on its rising edge.
REQ-005 SHALL have port system1000_rstn  in  1: reset, asynchronous, active-low.
REQ-006 SHALL have port scl_in  in  1: raw I2C SCL line, asynchronous to system1000.
REQ-007 SHALL have port sda_in  in  1: raw I2C SDA line, asynchronous to system1000.
REQ-008 SHALL have port sda_oe  out  1: 1 = pull SDA low (open-drain); 0 = release.
REQ-009 SHALL have port wr_en  out  1: one-cycle register write strobe.
REQ-010 SHALL have port wr_addr  out  PTR_W: register index for wr_en.
REQ-011 SHALL have port wr_data  out  8: data for wr_en.
REQ-012 SHALL have port rd_addr  out  PTR_W: register index being read; equals the current pointer.
REQ-013 SHALL have port rd_data  in  8: register contents; combinational from rd_addr, valid in the same cycle.
REQ-014 SHALL have port start_det  out  1: one-cycle pulse on each START or repeated START.
REQ-015 SHALL have port stop_det  out  1: one-cycle pulse on each STOP.
REQ-016 SHALL have port busy  out  1: high from an address-matched START until STOP.

Function
REQ-017 SHALL pass scl_in and sda_in through 2-flop synchronisers, then a 1-flop delayed copy for edge detection.
REQ-018 SHALL detect START when synced SDA falls while SCL is high, and STOP when synced SDA rises while SCL is high.
REQ-019 SHALL sample SDA on SCL rising edges and change sda_oe only on SCL falling edges.
REQ-020 SHALL use FSM states IDLE, DEV, DEV_ACK, PTR, PTR_ACK, WDAT, WDAT_ACK, RDAT, RDAT_ACK, and WAIT_STOP.
REQ-021 SHALL enter DEV from any state on START; a bit counter SHALL count 8 bits per byte and the ACK bit as the 9th.
REQ-022 SHALL ACK (sda_oe=1 for the 9th bit) in DEV only if the address equals DEV_ADDR; on mismatch it SHALL go to WAIT_STOP with sda_oe=0.
REQ-023 SHALL, after an address-matched ACK, go to PTR if the R/W bit is 0 and to RDAT if it is 1.
REQ-024 SHALL load the PTR byte into the pointer and ACK it if the value is < NREG; otherwise it SHALL NACK, leave the pointer unchanged, and go to WAIT_STOP.
REQ-025 SHALL, in WDAT, pulse wr_en for one cycle at the SCL falling edge that starts the ACK bit, with wr_addr = pointer and wr_data = byte, then ACK.
REQ-026 SHALL, in RDAT, capture rd_data into the shift register at the SCL falling edge that ends the address ACK or the previous data ACK, and drive it MSB first (sda_oe = ~bit).
REQ-027 SHALL, in RDAT_ACK, release SDA; a master ACK (SDA=0) SHALL continue RDAT, and a master NACK SHALL go to WAIT_STOP.
REQ-028 SHALL increment the pointer after each written byte and each read byte, wrapping from NREG-1 to 0.
REQ-029 SHALL retain the pointer across repeated START, so that a write-pointer-then-read sequence works.
REQ-030 SHALL, on STOP, go to IDLE, release SDA, and clear the bit counter; a STOP mid-byte SHALL discard the partial byte and SHALL NOT assert wr_en.
REQ-031 SHALL give START/STOP priority over bit processing when both occur in the same cycle.

Reset
REQ-032 SHALL, on reset, set FSM=IDLE, pointer=0, bit counter=0, shift register=0, sda_oe=0, wr_en=0, start_det=0, stop_det=0, busy=0, and synchroniser flops=1.
REQ-033 SHALL release SDA immediately when reset is asserted mid-transfer, and SHALL ignore the bus until the next START.

Configuration
REQ-034 SHALL, when I2C_SLAVE_REGS_GLITCH_FILTER_EN is defined, add a 3-sample majority filter on each synchronised line after the synchronisers, adding 2 cycles of latency.
REQ-035 SHALL, when I2C_SLAVE_REGS_GLITCH_FILTER_EN is undefined, feed the synchronised lines directly to edge detection; bus behaviour SHALL otherwise be identical.

Structure
REQ-036 SHALL place the FSM state enum and the bit-count constants (ACK_BIT=8) in shared package i2c_pkg.
REQ-037 SHALL place the synchroniser, optional filter, and START/STOP/edge detection in sub-module i2c_line_sync, instantiated once.

Verification
REQ-038 SHALL verify: write 0x84, 0x03, 0xA5, 0x5A, then STOP -> ACK on all four; wr_en pulses (3,0xA5) then (4,0x5A).
REQ-039 SHALL verify: write 0x84, 0x02, then repeated START, 0x85, read 2 bytes (ACK, then NACK) with rd_data=reg[2],reg[3] -> SDA bytes match; pointer ends at 4.
REQ-040 SHALL verify: send address 0x86 (0x43 write) -> NACK, sda_oe stays 0, no wr_en until STOP.
REQ-041 SHALL verify with NREG=16: write 0x84, 0x10 -> pointer byte NACKed; write 0x84, 0x0F, 0x11, 0x22 -> writes (15,0x11) and (0,0x22).
REQ-042 SHALL verify: STOP after 4 bits of a data byte -> no wr_en, stop_det pulses, busy=0; and reset asserted mid-read -> sda_oe=0 immediately.
